// File: rtl/uart_byte_rx_if.sv
// Byte-side signal bundle of the UART receiver: serial line in, byte/error strobes out.
// Carries parity_err only when UART_RX_PARITY_EN is defined.
interface uart_byte_rx_if;
  logic       rx_pin;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (
    input  rx_pin,
    output rx_valid, rx_data, frame_err, busy, state_dbg, parity_err
  );
  modport slave (
    output rx_pin,
    input  rx_valid, rx_data, frame_err, busy, state_dbg, parity_err
  );
`else
  modport master (
    input  rx_pin,
    output rx_valid, rx_data, frame_err, busy, state_dbg
  );
  modport slave (
    output rx_pin,
    input  rx_valid, rx_data, frame_err, busy, state_dbg
  );
`endif
endinterface

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1 (8E1 with UART_RX_PARITY_EN), mid-bit sampling, one-cycle strobes.
// Handshake: rx_valid/frame_err/parity_err are single-cycle strobes with no backpressure.
module uart_byte_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_rx_if.master rx_if
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_rate
      $error("uart_byte_rx: CLK_FREQ/BAUD_RATE must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q;
  logic        rx_s_q;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        bit_last;
  logic        half_last;
  logic        parity_ok;
`ifdef UART_RX_PARITY_EN
  logic        parity_bit_q, parity_bit_d;
  logic        parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_if.rx_pin;
      rx_s_q  <= sync1_q;
    end
  end

  assign bit_last  = (bit_cnt_q == BIT_LAST);
  assign half_last = (bit_cnt_q == HALF_LAST);

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = ~(^{shift_q, parity_bit_q});
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d   = ST_START;
          bit_cnt_d = 16'd0;
        end
      end

      ST_START: begin
        if (half_last) begin
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          // A start bit that has gone high again by mid-bit was a glitch.
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (bit_last) begin
          bit_cnt_d = 16'd0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_last) begin
          bit_cnt_d    = 16'd0;
          parity_bit_d = rx_s_q;
          state_d      = ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_last) begin
          bit_cnt_d = 16'd0;
          if (!rx_s_q) begin
            // Framing error wins over a parity error on the same frame.
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
            if (parity_ok) begin
              rx_valid_d = 1'b1;
              rx_data_d  = shift_q;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_err_d = 1'b1;
`endif
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_if.parity_err = parity_err_q;
`endif

  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.busy      = (state_q != ST_IDLE);
  assign rx_if.state_dbg = state_q;

endmodule
